fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds when disabled, bubbles on flush, reset or an empty load slot.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr_q,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_plus4_q,
    output logic            valid_q
);

    always_ff @(posedge clk) begin
        if (!rst_n || flush || (en && !load)) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (en) begin
            instr_q    <= instr;
            pc_q       <= pc;
            pc_plus4_q <= pc + PC_STEP;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, redirect tracking and a one-entry
// skid buffer that parks a fetched word while decode is stalled.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Stall_F,
    input  logic            Stall_D,
    input  logic            Flush_D,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PCPlus4_D,
    output logic            Valid_D,
    output logic            F_Wait
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc_f, pc_f_n;
    logic            req_active, req_active_n;
    logic            redir_pend, redir_pend_n;
    logic [XLEN-1:0] redir_pc, redir_pc_n;
    logic [XLEN-1:0] buf_instr, buf_instr_n;
    logic [XLEN-1:0] buf_pc, buf_pc_n;

    logic            xfer;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc;

    // A request that has gone out stays up regardless of Stall_F until it is answered.
    assign imem_req  = rst_n && (state == FETCH) && (req_active || !Stall_F);
    assign imem_addr = pc_f;
    assign F_Wait    = imem_req && !imem_ready;
    assign xfer      = imem_req && imem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc_f       <= RESET_PC;
            req_active <= 1'b0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
            buf_instr  <= '0;
            buf_pc     <= '0;
        end else begin
            state      <= state_n;
            pc_f       <= pc_f_n;
            req_active <= req_active_n;
            redir_pend <= redir_pend_n;
            redir_pc   <= redir_pc_n;
            buf_instr  <= buf_instr_n;
            buf_pc     <= buf_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_f_n       = pc_f;
        req_active_n = req_active;
        redir_pend_n = redir_pend;
        redir_pc_n   = redir_pc;
        buf_instr_n  = buf_instr;
        buf_pc_n     = buf_pc;
        ifid_load    = 1'b0;
        ifid_instr   = NOP_INSTR;
        ifid_pc      = '0;

        unique case (state)
            FETCH: begin
                if (xfer) begin
                    req_active_n = 1'b0;
                    if (PCSrc_E || redir_pend) begin
                        // Word belongs to the wrong path; drop it and steer to the redirect.
                        pc_f_n       = PCSrc_E ? PCTarget_E : redir_pc;
                        redir_pend_n = 1'b0;
                    end else if (!Stall_D) begin
                        ifid_load  = 1'b1;
                        ifid_instr = imem_rdata;
                        ifid_pc    = pc_f;
                        pc_f_n     = pc_f + PC_STEP;
                    end else begin
                        buf_instr_n = imem_rdata;
                        buf_pc_n    = pc_f;
                        state_n     = HOLD;
                    end
                end else if (imem_req) begin
                    req_active_n = 1'b1;
                    // Address must stay stable, so remember the first redirect for later.
                    if (PCSrc_E && !redir_pend) begin
                        redir_pend_n = 1'b1;
                        redir_pc_n   = PCTarget_E;
                    end
                end else if (PCSrc_E) begin
                    pc_f_n = PCTarget_E;
                end
            end
            HOLD: begin
                if (PCSrc_E) begin
                    pc_f_n  = PCTarget_E;
                    state_n = FETCH;
                end else if (!Stall_D) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_instr;
                    ifid_pc    = buf_pc;
                    pc_f_n     = buf_pc + PC_STEP;
                    state_n    = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (!Stall_D),
        .flush      (Flush_D),
        .load       (ifid_load),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .instr_q    (Instr_D),
        .pc_q       (PC_D),
        .pc_plus4_q (PCPlus4_D),
        .valid_q    (Valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues expected decode-stage instructions,
// a monitor pops and checks them whenever IF/ID takes a new valid instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall_F, Stall_D, Flush_D, PCSrc_E;
    logic [31:0] PCTarget_E;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_D, PC_D, PCPlus4_D;
    logic        Valid_D, F_Wait;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    bit monitor_done = 1'b0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Stall_F    (Stall_F),
        .Stall_D    (Stall_D),
        .Flush_D    (Flush_D),
        .PCSrc_E    (PCSrc_E),
        .PCTarget_E (PCTarget_E),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .Instr_D    (Instr_D),
        .PC_D       (PC_D),
        .PCPlus4_D  (PCPlus4_D),
        .Valid_D    (Valid_D),
        .F_Wait     (F_Wait)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive inputs just after a falling edge, then let combinational outputs settle.
    task automatic drive(input logic rn, input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt, input logic rdy);
        rst_n = rn; Stall_F = sf; Stall_D = sd; Flush_D = fd;
        PCSrc_E = ps; PCTarget_E = tgt; imem_ready = rdy;
        #1;
    endtask

    // Monitor: IF/ID gets a new entry on an edge with reset released, no stall and no flush.
    always @(posedge clk) begin
        logic sd, fl, rs;
        logic [31:0] e;
        sd = Stall_D; fl = Flush_D; rs = rst_n;
        #1;
        if (!monitor_done && rs && !sd && !fl && Valid_D) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_instr: got PC_D %h with nothing expected", PC_D);
            end else begin
                e = exp_q.pop_front();
                check("PC_D", PC_D, e);
                check("Instr_D", Instr_D, mem_word(e));
                check("PCPlus4_D", PCPlus4_D, e + 32'd4);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_fwait", 32'(F_Wait), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("reset_instr", Instr_D, NOP);
        check("reset_pc_d", PC_D, 32'h0);
        check("reset_pc4_d", PCPlus4_D, 32'h0);
        check("reset_valid", 32'(Valid_D), 32'd0);
        tick();

        // Back-to-back fetch with memory always ready.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("stream_req", 32'(imem_req), 32'd1);
            check("stream_addr", imem_addr, 32'(i * 4));
            exp_q.push_back(32'(i * 4));
            tick();
        end
        check("stream_valid", 32'(Valid_D), 32'd1);

        // Memory wait states at 0x10.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, 32'h10);
            check("wait_fwait", 32'(F_Wait), 32'd1);
            if (i > 0) check("wait_bubble", 32'(Valid_D), 32'd0);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wait_hold_req", 32'(imem_req), 32'd1);
        check("wait_done_fwait", 32'(F_Wait), 32'd0);
        exp_q.push_back(32'h10);
        tick();

        for (int a = 32'h14; a < 32'h20; a += 4) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("seq_addr", imem_addr, 32'(a));
            exp_q.push_back(32'(a));
            tick();
        end

        // Decode stall during the 0x20 transfer parks the word in HOLD.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("stall_addr", imem_addr, 32'h20);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_req", 32'(imem_req), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_release_req", 32'(imem_req), 32'd0);
        exp_q.push_back(32'h20);
        tick();

        for (int a = 32'h24; a < 32'h40; a += 4) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("seq2_addr", imem_addr, 32'(a));
            exp_q.push_back(32'(a));
            tick();
        end

        // Redirect to 0x100 while waiting at 0x40; a later redirect to 0x200 must lose.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_wait_addr", imem_addr, 32'h40);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        check("redir_addr_stable", imem_addr, 32'h40);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        check("redir_req_stable", 32'(imem_req), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_drop_addr", imem_addr, 32'h40);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_target", imem_addr, 32'h100);
        check("redir_no_valid", 32'(Valid_D), 32'd0);
        exp_q.push_back(32'h100);
        tick();

        // Flush together with stall forces a bubble.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("flush_addr", imem_addr, 32'h104);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("flush_instr", Instr_D, NOP);
        check("flush_valid", 32'(Valid_D), 32'd0);
        exp_q.push_back(32'h104);
        tick();

        // Redirect with no request outstanding, then PC wrap-around.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("idle_req", 32'(imem_req), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_addr_zero", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        tick();

        // Reset while waiting with a redirect pending.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_wait_fwait", 32'(F_Wait), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_fwait", 32'(F_Wait), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_mid_addr", imem_addr, 32'h0);
        check("rst_mid_valid", 32'(Valid_D), 32'd0);
        exp_q.push_back(32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_no_redir", imem_addr, 32'h4);
        exp_q.push_back(32'h4);
        tick();

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        monitor_done = 1'b1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
